// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared MEM/WB control-bit indices, default widths and bubble encoding.
package wb_stage_pkg;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int WB_REGWRITE    = 1;
    localparam int WB_MEMTOREG    = 0;
    localparam logic [1:0] WB_BUBBLE = 2'b00;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-side inputs, register-file write port and bypass outputs of the WB stage.
interface wb_stage_if
    import wb_stage_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
);
    logic [1:0]            wb_in;
    logic [DATA_W-1:0]     mem_data;
    logic [DATA_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] write_reg_in;
    logic                  valid_in;
    logic                  stall;
    logic                  flush;
    logic                  RegWrite;
    logic [DATA_W-1:0]     Writedata;
    logic [REG_ADDR_W-1:0] WriteReg;
    logic                  bypass_valid;
    logic [REG_ADDR_W-1:0] bypass_reg;
    logic [DATA_W-1:0]     bypass_data;
    modport master (
        output wb_in, mem_data, alu_result, write_reg_in, valid_in, stall, flush,
        input  RegWrite, Writedata, WriteReg, bypass_valid, bypass_reg, bypass_data
    );
    modport slave (
        input  wb_in, mem_data, alu_result, write_reg_in, valid_in, stall, flush,
        output RegWrite, Writedata, WriteReg, bypass_valid, bypass_reg, bypass_data
    );
endinterface

// File: rtl/wb_stage_bypass_reg.sv
// wb_bypass_reg: one-entry record of the last committed register write, live for one cycle.
module wb_bypass_reg
    import wb_stage_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0]     write_data,
    output logic                  valid,
    output logic [REG_ADDR_W-1:0] byp_reg,
    output logic [DATA_W-1:0]     byp_data
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            byp_reg  <= '0;
            byp_data <= '0;
        end else begin
            valid <= en;
            if (en) begin
                byp_reg  <= write_reg;
                byp_data <= write_data;
            end
        end
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage driving the register-file write port plus a one-cycle bypass.
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
`ifdef WB_RETIRE_COUNT_EN
    , parameter int CNT_W    = 32
`endif
) (
    input  logic clk,
    input  logic rst,
    wb_stage_if.slave bus
`ifdef WB_RETIRE_COUNT_EN
    , output logic [CNT_W-1:0] retire_count
`endif
);
    logic                  v_q;
    logic                  committed;
    logic [1:0]            wb_q;
    logic [DATA_W-1:0]     md_q;
    logic [DATA_W-1:0]     ar_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q       <= 1'b0;
            committed <= 1'b0;
            wb_q      <= WB_BUBBLE;
            md_q      <= '0;
            ar_q      <= '0;
            rd_q      <= '0;
        end else if (bus.flush) begin
            v_q       <= 1'b0;
            committed <= 1'b0;
            wb_q      <= WB_BUBBLE;
            md_q      <= '0;
            ar_q      <= '0;
            rd_q      <= '0;
        end else if (bus.stall) begin
            // a held instruction commits on its first edge only
            committed <= committed | v_q;
        end else begin
            v_q       <= bus.valid_in;
            committed <= 1'b0;
            wb_q      <= bus.wb_in;
            md_q      <= bus.mem_data;
            ar_q      <= bus.alu_result;
            rd_q      <= bus.write_reg_in;
        end
    end

    assign commit        = v_q & ~committed;
    assign bus.Writedata = wb_q[WB_MEMTOREG] ? md_q : ar_q;
    assign bus.WriteReg  = rd_q;
    assign bus.RegWrite  = v_q & wb_q[WB_REGWRITE] & (rd_q != '0);

    wb_bypass_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_bypass (
        .clk        (clk),
        .rst        (rst),
        .en         (bus.RegWrite & ~committed),
        .write_reg  (bus.WriteReg),
        .write_data (bus.Writedata),
        .valid      (bus.bypass_valid),
        .byp_reg    (bus.bypass_reg),
        .byp_data   (bus.bypass_data)
    );

`ifdef WB_RETIRE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retire_count <= '0;
        else if (commit)
            retire_count <= retire_count + 1'b1;
    end
`else
    logic unused_commit;
    assign unused_commit = commit;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: vector table, directed stall/flush/reset/wrap sequences and a randomized model check.
module tb_wb_stage;
    import wb_stage_pkg::*;
`ifdef WB_RETIRE_COUNT_EN
    localparam int CNT_W = 4;
    logic [CNT_W-1:0] retire_count;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

    wb_stage #(
        .DATA_W(32), .REG_ADDR_W(5)
`ifdef WB_RETIRE_COUNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef WB_RETIRE_COUNT_EN
        , .retire_count (retire_count)
`endif
    );

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] md;
        logic [31:0] ar;
        logic [4:0]  rd;
        logic        v;
        logic        rw;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
    } vec_t;

    typedef struct {
        logic        v;
        logic [1:0]  wb;
        logic [31:0] md;
        logic [31:0] ar;
        logic [4:0]  rd;
        int          id;
        logic        flushed;
    } stage_t;

    stage_t      st;
    int          next_id;
    int          last_ret;
    logic        m_bv;
    logic [4:0]  m_br;
    logic [31:0] m_bd;
    int unsigned m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] wb, input logic [31:0] md, input logic [31:0] ar,
                         input logic [4:0] rd, input logic v, input logic s, input logic f);
        bus.wb_in = wb;
        bus.mem_data = md;
        bus.alu_result = ar;
        bus.write_reg_in = rd;
        bus.valid_in = v;
        bus.stall = s;
        bus.flush = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        st = '{v: 1'b0, wb: 2'b00, md: 32'h0, ar: 32'h0, rd: 5'h0, id: -1, flushed: 1'b0};
        next_id = 0;
        last_ret = -1;
        m_bv = 1'b0;
        m_br = 5'h0;
        m_bd = 32'h0;
        m_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b00, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        model_reset();
    endtask

    // Each instruction carries an id; it retires (and writes the bypass) the first edge it is seen.
    task automatic model_edge();
        bit fresh;
        bit writes;
        fresh  = st.v && (st.id != last_ret);
        writes = st.v && st.wb[1] && (st.rd != 0);
        if (fresh) begin
            last_ret = st.id;
            m_cnt++;
        end
        m_bv = fresh && writes;
        if (m_bv) begin
            m_br = st.rd;
            m_bd = st.wb[0] ? st.md : st.ar;
        end
        if (bus.flush)
            st = '{v: 1'b0, wb: 2'b00, md: 32'h0, ar: 32'h0, rd: 5'h0, id: -1, flushed: 1'b1};
        else if (!bus.stall) begin
            st = '{v: bus.valid_in, wb: bus.wb_in, md: bus.mem_data, ar: bus.alu_result,
                   rd: bus.write_reg_in, id: next_id, flushed: 1'b0};
            next_id++;
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'b00, 32'h0,         32'h0,     5'd0, 1'b0, 1'b0, 32'h0,         5'd0, 1'b0, 5'd0, 32'h0};
        vecs[1] = '{2'b10, 32'h0,         32'h1234,  5'd8, 1'b1, 1'b1, 32'h1234,      5'd8, 1'b0, 5'd0, 32'h0};
        vecs[2] = '{2'b11, 32'hDEADBEEF,  32'h40,    5'd9, 1'b1, 1'b1, 32'hDEADBEEF,  5'd9, 1'b1, 5'd8, 32'h1234};
        vecs[3] = '{2'b10, 32'h0,         32'h55,    5'd0, 1'b1, 1'b0, 32'h55,        5'd0, 1'b1, 5'd9, 32'hDEADBEEF};
        vecs[4] = '{2'b00, 32'h0,         32'h0,     5'd0, 1'b0, 1'b0, 32'h0,         5'd0, 1'b0, 5'd9, 32'hDEADBEEF};
        vecs[5] = '{2'b10, 32'h0,         32'h77,    5'd3, 1'b0, 1'b0, 32'h77,        5'd3, 1'b0, 5'd9, 32'hDEADBEEF};
        vecs[6] = '{2'b01, 32'hAA,        32'hBB,    5'd4, 1'b1, 1'b0, 32'hAA,        5'd4, 1'b0, 5'd9, 32'hDEADBEEF};
        vecs[7] = '{2'b00, 32'h0,         32'h0,     5'd0, 1'b0, 1'b0, 32'h0,         5'd0, 1'b0, 5'd9, 32'hDEADBEEF};

        drive(2'b00, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        chk("reset_rw", bus.RegWrite, 0);
        chk("reset_wd", bus.Writedata, 0);
        chk("reset_wr", bus.WriteReg, 0);
        chk("reset_bv", bus.bypass_valid, 0);
        chk("reset_br", bus.bypass_reg, 0);
        chk("reset_bd", bus.bypass_data, 0);
`ifdef WB_RETIRE_COUNT_EN
        chk("reset_cnt", retire_count, 0);
`endif
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_rw", bus.RegWrite, 0);
        end

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].wb, vecs[i].md, vecs[i].ar, vecs[i].rd, vecs[i].v, 1'b0, 1'b0);
            step();
            chk($sformatf("vec%0d_rw", i), bus.RegWrite, vecs[i].rw);
            chk($sformatf("vec%0d_wd", i), bus.Writedata, vecs[i].wd);
            chk($sformatf("vec%0d_wr", i), bus.WriteReg, vecs[i].wr);
            chk($sformatf("vec%0d_bv", i), bus.bypass_valid, vecs[i].bv);
            chk($sformatf("vec%0d_br", i), bus.bypass_reg, vecs[i].br);
            chk($sformatf("vec%0d_bd", i), bus.bypass_data, vecs[i].bd);
        end

        // stall a write to $5 for three cycles, then stall+flush together
        do_reset();
        drive(2'b10, 32'h0, 32'h555, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        chk("stall_cap_rw", bus.RegWrite, 1);
        chk("stall_cap_bv", bus.bypass_valid, 0);
        drive(2'b10, 32'h0, 32'h666, 5'd6, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d_rw", i), bus.RegWrite, 1);
            chk($sformatf("stall%0d_wr", i), bus.WriteReg, 5);
            chk($sformatf("stall%0d_wd", i), bus.Writedata, 32'h555);
            chk($sformatf("stall%0d_bv", i), bus.bypass_valid, (i == 0));
            chk($sformatf("stall%0d_br", i), bus.bypass_reg, 5);
        end
        drive(2'b10, 32'h0, 32'h666, 5'd6, 1'b1, 1'b1, 1'b1);
        step();
        chk("stflush_rw", bus.RegWrite, 0);
        chk("stflush_bv", bus.bypass_valid, 0);
        chk("stflush_br", bus.bypass_reg, 5);
        chk("stflush_bd", bus.bypass_data, 32'h555);
`ifdef WB_RETIRE_COUNT_EN
        chk("stall_cnt", retire_count, 1);
`endif

        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            model_edge();
            step();
            chk("rnd_rw", bus.RegWrite, st.v && st.wb[1] && (st.rd != 0));
            if (!st.flushed) begin
                chk("rnd_wd", bus.Writedata, st.wb[0] ? st.md : st.ar);
                chk("rnd_wr", bus.WriteReg, st.rd);
            end
            chk("rnd_bv", bus.bypass_valid, m_bv);
            chk("rnd_br", bus.bypass_reg, m_br);
            chk("rnd_bd", bus.bypass_data, m_bd);
`ifdef WB_RETIRE_COUNT_EN
            chk("rnd_cnt", retire_count, CNT_W'(m_cnt));
`endif
        end

        // asynchronous reset in the middle of a cycle
        do_reset();
        drive(2'b10, 32'h0, 32'h777, 5'd7, 1'b1, 1'b1, 1'b0);
        bus.stall = 1'b0;
        step();
        bus.stall = 1'b1;
        step();
        chk("pre_arst_rw", bus.RegWrite, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_rw", bus.RegWrite, 0);
        chk("arst_wd", bus.Writedata, 0);
        chk("arst_bv", bus.bypass_valid, 0);
        chk("arst_br", bus.bypass_reg, 0);
`ifdef WB_RETIRE_COUNT_EN
        chk("arst_cnt", retire_count, 0);
`endif
        rst = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("post_arst_rw", bus.RegWrite, 0);
        chk("post_arst_bv", bus.bypass_valid, 0);

`ifdef WB_RETIRE_COUNT_EN
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(2'b00, 32'h0, 32'(i), 5'(i), 1'b1, 1'b0, 1'b0);
            step();
        end
        drive(2'b00, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("wrap_cnt", 64'(retire_count), 64'(longint'(17) % (longint'(1) << CNT_W)));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
